// File: rtl/ex_mem_wb_pipe.sv
// rtl/ex_mem_wb_pipe.sv - EX/MEM and MEM/WB pipeline banks with data-memory stall and halt control
// Optional STALL_CNT_EN adds a saturating count of memory-stall cycles on stall_cnt.
module ex_mem_wb_pipe (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_memwrite,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_storedata,
    input  logic        ex_halt,
    input  logic        flush,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        mem_busy,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_regwrite,
    output logic [31:0] ex_mem_aluout,
    output logic        ex_mem_memtoreg,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_regwrite,
    output logic [31:0] mem_wb_wdata,
`ifdef STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        halt
);

    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

    state_t      state;
    state_t      next_state;

    logic        em_valid;
    logic [4:0]  em_rd;
    logic        em_regwrite;
    logic        em_memtoreg;
    logic        em_memwrite;
    logic [31:0] em_aluout;
    logic [31:0] em_storedata;
    logic        em_halt;

    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_wdata;

    logic        advance;
    logic        halt_adv;

    assign halt      = (state == HALT);
    // Requests are gated in HALT so nothing trailing a halt can reach memory.
    assign dmemREN   = !halt && em_valid && em_memtoreg;
    assign dmemWEN   = !halt && em_valid && em_memwrite;
    assign dmemaddr  = em_aluout;
    assign dmemstore = em_storedata;
    assign mem_busy  = (dmemREN || dmemWEN) && !dhit;

    assign advance   = !halt && !mem_busy;
    assign halt_adv  = advance && em_valid && em_halt;

    assign ex_mem_rd       = em_rd;
    assign ex_mem_regwrite = em_valid && em_regwrite && (em_rd != 5'd0);
    assign ex_mem_aluout   = em_aluout;
    assign ex_mem_memtoreg = em_valid && em_memtoreg;
    assign mem_wb_rd       = wb_rd;
    assign mem_wb_regwrite = wb_regwrite && (wb_rd != 5'd0);
    assign mem_wb_wdata    = wb_wdata;

    always_comb begin
        next_state = state;
        case (state)
            RUN, WAIT: begin
                if (mem_busy)
                    next_state = WAIT;
                else if (halt_adv)
                    next_state = HALT;
                else
                    next_state = RUN;
            end
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            em_valid     <= 1'b0;
            em_rd        <= 5'd0;
            em_regwrite  <= 1'b0;
            em_memtoreg  <= 1'b0;
            em_memwrite  <= 1'b0;
            em_aluout    <= 32'd0;
            em_storedata <= 32'd0;
            em_halt      <= 1'b0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            wb_wdata     <= 32'd0;
        end else begin
            state <= next_state;
            if (!halt && mem_busy) begin
                wb_rd       <= 5'd0;
                wb_regwrite <= 1'b0;
                wb_wdata    <= 32'd0;
            end else if (advance) begin
                wb_rd       <= em_rd;
                wb_regwrite <= em_valid && em_regwrite;
                wb_wdata    <= ex_mem_memtoreg ? dmemload : em_aluout;
                // The slot behind a retiring halt is squashed before it can request memory.
                if (flush || !ex_valid || halt_adv) begin
                    em_valid     <= 1'b0;
                    em_rd        <= 5'd0;
                    em_regwrite  <= 1'b0;
                    em_memtoreg  <= 1'b0;
                    em_memwrite  <= 1'b0;
                    em_aluout    <= 32'd0;
                    em_storedata <= 32'd0;
                    em_halt      <= 1'b0;
                end else begin
                    em_valid     <= 1'b1;
                    em_rd        <= ex_rd;
                    em_regwrite  <= ex_regwrite;
                    em_memtoreg  <= ex_memtoreg;
                    em_memwrite  <= ex_memwrite;
                    em_aluout    <= ex_aluout;
                    em_storedata <= ex_storedata;
                    em_halt      <= ex_halt;
                end
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST)
            stall_cnt <= 32'd0;
        else if (mem_busy && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
